seq_magnitude_comparator: RTL

//  Parametrised, multi-cycle magnitude comparator: next generation of the 8-bit

---
 rtl/cmp_pkg.sv | 29 ++
 rtl/comparator_chunk.sv | 16 +
 rtl/seq_magnitude_comparator.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM state
// encoding, one-hot result constants and a ceiling-log2 helper.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result vectors are packed as {lt, eq, gt}
  localparam logic [2:0] RES_LT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_GT = 3'b001;

  // Number of bits needed to count 0..n-1
  function automatic int CLOG2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module comparator_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands MSB chunk first,
// stops on the first differing chunk, and falls back to the cascade inputs
// when every chunk matches.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CHUNK     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             LT_IN,
  input  logic             EQ_IN,
  input  logic             GT_IN,
  output logic             busy,
  output logic             done,
  output logic             LT_OUT,
  output logic             EQ_OUT,
  output logic             GT_OUT
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? CLOG2(NCHUNK) : 1;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       cas_reg;   // {LT_IN, EQ_IN, GT_IN} captured at start
  logic             mode_reg;
  logic [2:0]       res_reg;   // {lt, eq, gt}

  // Chunk arrays ordered MSB-first so the counter indexes them directly
  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_chunks[gi] = a_reg[(NCHUNK-1-gi)*CHUNK +: CHUNK];
      assign b_chunks[gi] = b_reg[(NCHUNK-1-gi)*CHUNK +: CHUNK];
    end
  endgenerate

  // Flipping the top bit of the most significant chunk turns a two's-complement
  // compare into an unsigned one; lower chunks are plain magnitude bits.
  localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

  logic             first_chunk;
  logic             last_chunk;
  logic [CHUNK-1:0] sign_flip;
  logic [CHUNK-1:0] a_cmp;
  logic [CHUNK-1:0] b_cmp;
  logic             chk_lt;
  logic             chk_eq;
  logic             chk_gt;

  assign first_chunk = (cnt_reg == '0);
  assign last_chunk  = (cnt_reg == CNT_W'(NCHUNK - 1));
  assign sign_flip   = (mode_reg && first_chunk) ? MSB_MASK : '0;
  assign a_cmp       = a_chunks[cnt_reg] ^ sign_flip;
  assign b_cmp       = b_chunks[cnt_reg] ^ sign_flip;

  comparator_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a  (a_cmp),
    .b  (b_cmp),
    .lt (chk_lt),
    .eq (chk_eq),
    .gt (chk_gt)
  );

  // Cascade resolution when all chunks match: EQ_IN wins, then GT_IN, then LT_IN
  logic [2:0] cas_res;
  always_comb begin
    cas_res = RES_EQ;
    if (cas_reg[1])      cas_res = RES_EQ;
    else if (cas_reg[0]) cas_res = RES_GT;
    else if (cas_reg[2]) cas_res = RES_LT;
  end

  // FSM, chunk counter, operand capture and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      cas_reg   <= '0;
      mode_reg  <= 1'b0;
      res_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_reg     <= A;
            b_reg     <= B;
            cas_reg   <= {LT_IN, EQ_IN, GT_IN};
            mode_reg  <= signed_mode & SIGNED_EN;
            cnt_reg   <= '0;
            state_reg <= CMP;
          end else begin
            state_reg <= IDLE;
          end
        end
        CMP: begin
          if (!chk_eq) begin
            res_reg   <= {chk_lt, 1'b0, chk_gt};
            state_reg <= DONE;
          end else if (last_chunk) begin
            res_reg   <= cas_res;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy   = (state_reg == CMP);
  assign done   = (state_reg == DONE);
  assign LT_OUT = res_reg[2];
  assign EQ_OUT = res_reg[1];
  assign GT_OUT = res_reg[0];

endmodule
